// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: operation and
// state encodings, the fixed load-upper distance, and the per-cycle step
// amount helper.
package shift_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_LUI = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Load-upper is a left shift of the low half by a fixed 16 bits.
   localparam logic [4:0] LUI_SHAMT = 5'd16;

   // Bits to shift this cycle: the smaller of the step limit and what is left.
   function automatic logic [4:0] stepAmount(input logic [4:0] remaining,
                                             input logic [4:0] stepMax);
      return (remaining < stepMax) ? remaining : stepMax;
   endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request/response bundle between the execute stage and the shift sequencer.
// The master issues requests and aborts; the slave reports status and result.
interface shift_seq_if;
   import shift_pkg::*;

   logic        start;
   op_t         op;
   logic [31:0] src;
   logic [4:0]  shamt;
   logic        clr;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] result;

   modport master (
      output start, op, src, shamt, clr,
      input  ready, busy, done, result
   );

   modport slave (
      input  start, op, src, shamt, clr,
      output ready, busy, done, result
   );

endinterface

// File: rtl/shift_seq_step.sv
// Combinational single-step shifter: moves the working value by k bits in the
// direction implied by the operation. SRA fills vacated high bits with the
// latched operand sign rather than the current MSB.
module shift_step
   import shift_pkg::*;
(
   input  logic [31:0] value,
   input  logic [4:0]  k,
   input  op_t         op,
   input  logic        sign,
   output logic [31:0] shifted
);

   logic [31:0] fillMask;

   // High bits vacated by a right shift of k; OR-ed in for the SRA sign fill.
   assign fillMask = ~(32'hFFFF_FFFF >> k);

   // Select the shift direction and fill for the current operation.
   always_comb begin
      shifted = value << k;
      case (op)
         OP_SRL:  shifted = value >> k;
         OP_SRA:  shifted = (value >> k) | (sign ? fillMask : 32'h0);
         default: shifted = value << k;
      endcase
   end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer. Accepts one shift or load-upper request per
// handshake, then iterates a small shifter STEP bits at a time until the shift
// amount is consumed, presenting the result with a one-cycle done pulse.
module shift_seq
   import shift_pkg::*;
#(
   parameter int STEP = 1   // bits per RUN cycle: 1, 2, 4, 8 or 16
)
(
   input  logic        clk,
   input  logic        reset,
   shift_seq_if.slave  bus
);

   localparam logic [4:0] STEP_K = 5'(STEP);

   state_t      stateReg;
   logic [31:0] workReg;
   logic [31:0] resultReg;
   logic [4:0]  remainingReg;
   op_t         opReg;
   logic        signReg;

   logic [4:0]  stepK;
   logic [4:0]  remainingNext;
   logic [31:0] shifted;
   logic [31:0] loadValue;
   logic [4:0]  loadRemaining;

   assign stepK         = stepAmount(remainingReg, STEP_K);
   assign remainingNext = remainingReg - stepK;

   // Operand and shift count captured on accept; LUI takes the zero-extended
   // low half and a fixed distance, ignoring shamt.
   assign loadValue     = (bus.op == OP_LUI) ? {16'h0, bus.src[15:0]} : bus.src;
   assign loadRemaining = (bus.op == OP_LUI) ? LUI_SHAMT : bus.shamt;

   shift_step uStep (
      .value   (workReg),
      .k       (stepK),
      .op      (opReg),
      .sign    (signReg),
      .shifted (shifted)
   );

   // Sequencer FSM: accept in IDLE/DONE, iterate in RUN, publish the result on
   // the edge entering DONE. clr aborts without touching the published result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg     <= S_IDLE;
         workReg      <= 32'h0;
         resultReg    <= 32'h0;
         remainingReg <= 5'd0;
         opReg        <= OP_SLL;
         signReg      <= 1'b0;
      end else if (bus.clr) begin
         stateReg <= S_IDLE;
      end else begin
         case (stateReg)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  workReg      <= loadValue;
                  opReg        <= bus.op;
                  signReg      <= bus.src[31];
                  remainingReg <= loadRemaining;
                  if (loadRemaining == 5'd0) begin
                     // Nothing to shift: the operand itself is the result.
                     resultReg <= loadValue;
                     stateReg  <= S_DONE;
                  end else begin
                     stateReg <= S_RUN;
                  end
               end else begin
                  stateReg <= S_IDLE;
               end
            end
            S_RUN: begin
               workReg      <= shifted;
               remainingReg <= remainingNext;
               if (remainingNext == 5'd0) begin
                  resultReg <= shifted;
                  stateReg  <= S_DONE;
               end
            end
            default: stateReg <= S_IDLE;
         endcase
      end
   end

   // Status outputs decode the registered state only; start never reaches them.
   assign bus.ready  = (stateReg == S_IDLE) || (stateReg == S_DONE);
   assign bus.busy   = (stateReg == S_RUN);
   assign bus.done   = (stateReg == S_DONE);
   assign bus.result = resultReg;

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer for the CPU execute stage. It accepts one shift or load-upper request per handshake and iterates a small per-cycle shifter until the shift amount is consumed. It then presents the 32-bit result with a one-cycle `done` pulse. The stall logic uses `busy` to hold the pipeline while a shift is in flight.

## Interface
- `STEP`, default 1: maximum bits shifted per RUN cycle; legal values 1, 2, 4, 8, 16.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  request strobe; sampled only when `ready`=1.
- `op`  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 LUI.
- `src`  in  32  operand. LUI uses `src[15:0]` zero-extended.
- `shamt`  in  5  shift amount; ignored for LUI, which uses a fixed 16.
- `clr`  in  1  synchronous abort; highest priority after reset.
- `ready`  out  1  high in IDLE and DONE.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse, high in DONE.
- `result`  out  32  last completed result; held until the next completion.

## Operation
- **States:** IDLE, RUN, DONE.
- **Accept:** `start`=1 while `ready`=1.
  - Latch the working register: `src`, or `{16'b0, src[15:0]}` for LUI.
  - Latch `op`.
  - Load `remaining`: `shamt`, or 16 for LUI.
  - Go to RUN if `remaining` is nonzero, otherwise go straight to DONE.
- **RUN cycle:**
  - Shift the working register by k = min(STEP, `remaining`), then `remaining` -= k.
  - SLL and LUI fill with 0 on the right. SRL fills with 0 on the left. SRA fills with `src[31]` on the left.
  - When `remaining` reaches 0 after this cycle, go to DONE.
- **DONE cycle:**
  - Copy the working register to `result`; `done`=1.
  - With `start`=1 the next request is accepted: back-to-back, no IDLE bubble.
  - Otherwise go to IDLE.
- **Ignored starts:** `start` during RUN is ignored, not queued. The requester holds `start` until it sees `ready`.
- **clr:** in any state, go to IDLE next cycle.
  - Discard the in-flight operation; `result` is unchanged; `done` is not pulsed.
  - `clr` together with `start` in the same cycle: `clr` wins and nothing is accepted.
- **Reset:** state IDLE, working register 0, `remaining` 0, `result` 0.
  - Outputs: `ready`=1, `busy`=0, `done`=0.
  - Reset mid-RUN abandons the operation immediately (asynchronous).
- **Width rules:** `remaining` is 5 bits; `shamt`=31 is legal. A shift by k never exceeds 16 bits per cycle. All arithmetic is unsigned except the SRA fill.

## Timing
- Accept edge is cycle 0; RUN occupies cycles 1 to N, where N = ceil(n/STEP).
- `done` and the new `result` are visible in cycle N+1. With n=0, `done` appears in cycle 1.
- Throughput with back-to-back requests: one result per N+1 cycles.
- `ready`, `busy` and `done` are registered-state decodes; there is no combinational path from `start` to any output.
- `result` changes only on the edge entering DONE.

## Structure
- **Package `shift_pkg`:**
  - op encodings `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_LUI`;
  - state encoding `S_IDLE`, `S_RUN`, `S_DONE`;
  - constant `LUI_SHAMT`=16.
- **Sub-module `shift_step`:** combinational. Inputs are value (32), k (5), op and sign. Output is the value shifted by k. It is instantiated once; the FSM, counter and registers live in `shift_seq`.

## Test plan
- **SLL, STEP=1:** reset released, `op`=00, `src`=0x0000_0001, `shamt`=4 → `busy` for 4 cycles; `done` at cycle 5; `result`=0x0000_0010.
- **SRA, STEP=4:** `op`=10, `src`=0x8000_0000, `shamt`=31 → 8 RUN cycles; `result`=0xFFFF_FFFF. SRL with the same operands gives 0x0000_0001.
- **LUI:** `op`=11, `src`=0xABCD_1234, `shamt`=3 (ignored) → `result`=0x1234_0000 after 16 RUN cycles with STEP=1, or 1 RUN cycle with STEP=16.
- **Zero shift and back-to-back:** `shamt`=0 with `src`=0xDEAD_BEEF → `done` in cycle 1 with the same value. With `start` held in DONE, the second request (SLL by 1 of 0x1) is accepted without an IDLE cycle and yields 0x2.
- **Ignored start and clr:** `start` asserted mid-RUN → no effect on `result`. `clr` in RUN → IDLE next cycle, no `done`, `result` still the previous value.
- **Async reset mid-RUN:** `reset` low mid-RUN → `busy`=0 and `result`=0 immediately, without waiting for a clock edge. After release, a fresh SLL by 2 of 0x3 returns 0xC.
